button_event: RTL and testbench

- Sits directly downstream of the debounce stage and consumes its clean level output `o` as input `i`.
- Converts the held or released level into single-cycle event pulses:
  - press
  - release
  - short press
  - long press
  - optional auto-repeat while held
- Also keeps a running press count.
- Drives the parameter-adjust logic of the ball-tracking design, e.g. threshold up/down buttons.

---
 rtl/button_event_if.sv | 32 +++
 rtl/button_event.sv | 131 +++++++++++++
 tb/tb_button_event.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/button_event_if.sv
// button_event_if: bundles the debounced button level and the event outputs
// of button_event.
//   i           debounced button level (from the debounce stage)
//   press       1-cycle pulse on the press edge
//   release_ev  1-cycle pulse on the release edge
//   short_press 1-cycle pulse on a release before the long threshold
//   long_press  1-cycle pulse when the hold reaches the long threshold
//   repeat_ev   1-cycle auto-repeat pulse while long-held
//   held        registered level, 1 from the press edge until release
//   press_cnt   number of presses, modulo 256
// modport slave is used by button_event; modport master is used by the
// logic that drives the level and consumes the events.
interface button_event_if;
  logic       i;
  logic       press;
  logic       release_ev;
  logic       short_press;
  logic       long_press;
  logic       repeat_ev;
  logic       held;
  logic [7:0] press_cnt;

  modport master (
    output i,
    input  press, release_ev, short_press, long_press, repeat_ev, held, press_cnt
  );

  modport slave (
    input  i,
    output press, release_ev, short_press, long_press, repeat_ev, held, press_cnt
  );
endinterface

// File: rtl/button_event.sv
// button_event: turns the debounced button level into single-cycle events
// (press, release, short press, long press, optional auto-repeat), a held
// level and a modulo-256 press counter. All outputs are registered.
// Ports:
//   clk  system clock, rising edge
//   clr  asynchronous active-low reset
//   bus  button_event_if.slave (i in; events, held, press_cnt out)
// Parameters:
//   LONG_CYC   hold cycles from press to long_press (2 .. 2^CW-1)
//   REPEAT_CYC cycles between repeat pulses once long-held (1 .. 2^CW-1)
//   CW         width of the hold and repeat counters
// Build option: define BTN_AUTO_REPEAT_EN to include the auto-repeat logic;
// without it repeat_ev is constant 0 and LONG_HELD only waits for release.
module button_event #(
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned CW         = 27
) (
  input logic           clk,
  input logic           clr,
  button_event_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);

  state_t        state;
  logic          i_q;
  logic [CW-1:0] hold_cnt;
  logic          press_q;
  logic          rel_q;
  logic          short_q;
  logic          long_q;
  logic          rpt_q;
  logic          held_q;
  logic [7:0]    cnt_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYC - 1);
  logic [CW-1:0] rep_cnt;
`else
  // No repeat logic: the pulse is a constant low (REPEAT_CYC is irrelevant).
  assign rpt_q = (REPEAT_CYC == 0) & 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      i_q      <= 1'b0;
      hold_cnt <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_cnt  <= '0;
      rpt_q    <= 1'b0;
`endif
    end else begin
      i_q     <= bus.i;
      // Event pulses default low so each lasts exactly one cycle.
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.i && !i_q) begin
            press_q  <= 1'b1;
            held_q   <= 1'b1;
            cnt_q    <= cnt_q + 8'd1;
            hold_cnt <= '0;
            state    <= PRESSED;
          end
        end
        PRESSED: begin
          // Release is tested first so it wins over a coincident long threshold.
          if (!bus.i) begin
            rel_q   <= 1'b1;
            short_q <= 1'b1;
            held_q  <= 1'b0;
            state   <= IDLE;
          end else if (hold_cnt == LONG_LAST) begin
            long_q <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt <= '0;
`endif
            state  <= LONG_HELD;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG_HELD: begin
          if (!bus.i) begin
            rel_q  <= 1'b1;
            held_q <= 1'b0;
            state  <= IDLE;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            rpt_q   <= 1'b1;
            rep_cnt <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.press       = press_q;
  assign bus.release_ev  = rel_q;
  assign bus.short_press = short_q;
  assign bus.long_press  = long_q;
  assign bus.repeat_ev   = rpt_q;
  assign bus.held        = held_q;
  assign bus.press_cnt   = cnt_q;

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed self-checking bench for button_event with
// LONG_CYC=8, REPEAT_CYC=4, CW=4. Event vectors are ordered
// {press, release_ev, short_press, long_press, repeat_ev, held}.
module tb_button_event;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  button_event_if bus ();

  button_event #(
    .LONG_CYC  (8),
    .REPEAT_CYC(4),
    .CW        (4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the level, then let one rising edge sample it and settle.
  task automatic step(input logic v);
    bus.i = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ev();
    return {bus.press, bus.release_ev, bus.short_press,
            bus.long_press, bus.repeat_ev, bus.held};
  endfunction

  task automatic test_reset();
    logic [5:0] e;
    for (int k = 0; k < 5; k++) begin
      step(k % 2 == 0);
      checks++;
      if (ev() !== 6'b0 || bus.press_cnt !== 8'd0) begin
        failures++;
        $display("FAIL reset_hold k=%0d ev=%b cnt=%0d expected ev=000000 cnt=0", k, ev(), bus.press_cnt);
      end
    end
    bus.i = 1'b0;
    #1;
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      e = 6'b0;
      checks++;
      if (ev() !== e || bus.press_cnt !== 8'd0) begin
        failures++;
        $display("FAIL reset_release k=%0d ev=%b cnt=%0d expected ev=%b cnt=0", k, ev(), bus.press_cnt, e);
      end
    end
  endtask

  task automatic test_short_press();
    logic [5:0] e;
    for (int k = 0; k <= 3; k++) begin
      step(k < 3);
      e = {k == 0, k == 3, k == 3, 1'b0, 1'b0, k < 3};
      checks++;
      if (ev() !== e) begin
        failures++;
        $display("FAIL short_press k=%0d ev=%b expected %b", k, ev(), e);
      end
    end
    checks++;
    if (bus.press_cnt !== 8'd1) begin
      failures++;
      $display("FAIL short_cnt cnt=%0d expected 1", bus.press_cnt);
    end
    step(1'b0);
  endtask

  task automatic test_long_repeat();
    logic [5:0] e;
    for (int k = 0; k <= 20; k++) begin
      step(k < 20);
      e = {k == 0, k == 20, 1'b0, k == 8, AR && (k == 12 || k == 16), k < 20};
      checks++;
      if (ev() !== e) begin
        failures++;
        $display("FAIL long_repeat k=%0d ev=%b expected %b", k, ev(), e);
      end
    end
    checks++;
    if (bus.press_cnt !== 8'd2) begin
      failures++;
      $display("FAIL long_cnt cnt=%0d expected 2", bus.press_cnt);
    end
    step(1'b0);
  endtask

  task automatic test_boundary();
    logic [5:0] e;
    for (int k = 0; k <= 8; k++) begin
      step(k < 8);
      e = {k == 0, k == 8, k == 8, 1'b0, 1'b0, k < 8};
      checks++;
      if (ev() !== e) begin
        failures++;
        $display("FAIL boundary k=%0d ev=%b expected %b", k, ev(), e);
      end
    end
    checks++;
    if (bus.press_cnt !== 8'd3) begin
      failures++;
      $display("FAIL boundary_cnt cnt=%0d expected 3", bus.press_cnt);
    end
    step(1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_cnt;
    clr = 1'b0;
    #1;
    clr = 1'b1;
    bus.i = 1'b0;
    for (int n = 1; n <= 257; n++) begin
      step(1'b1);
      exp_cnt = 8'(n % 256);
      checks++;
      if (bus.press_cnt !== exp_cnt || bus.press !== 1'b1) begin
        failures++;
        $display("FAIL wrap n=%0d cnt=%0d press=%b expected cnt=%0d press=1", n, bus.press_cnt, bus.press, exp_cnt);
      end
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] e;
    for (int k = 0; k < 5; k++) step(1'b1);
    clr = 1'b0;
    #1;
    checks++;
    if (ev() !== 6'b0 || bus.press_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset_async ev=%b cnt=%0d expected ev=000000 cnt=0", ev(), bus.press_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1);
      checks++;
      if (ev() !== 6'b0) begin
        failures++;
        $display("FAIL mid_reset_quiet k=%0d ev=%b expected 000000", k, ev());
      end
    end
    clr = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step(1'b1);
      e = {k == 0, 1'b0, 1'b0, k == 8, AR && (k == 12), 1'b1};
      checks++;
      if (ev() !== e) begin
        failures++;
        $display("FAIL mid_reset_rehold k=%0d ev=%b expected %b", k, ev(), e);
      end
    end
    checks++;
    if (bus.press_cnt !== 8'd1) begin
      failures++;
      $display("FAIL mid_reset_cnt cnt=%0d expected 1", bus.press_cnt);
    end
    step(1'b0);
    e = 6'b010000;
    checks++;
    if (ev() !== e) begin
      failures++;
      $display("FAIL mid_reset_release ev=%b expected %b", ev(), e);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b0;
    bus.i    = 1'b0;
    #1;
    test_reset();
    test_short_press();
    test_long_repeat();
    test_boundary();
    test_wrap();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded 1000000 time units");
    $fatal(1, "timeout");
  end

endmodule
